// File: rtl/apb_cmd_master.sv
// APB3/APB4 master bridge: buffers {write, strb, addr, data} commands in a FIFO,
// issues one APB transfer per command and returns one response per command.
module apb_cmd_master #(
  parameter int DATA_WD    = 32,
  parameter int ADDR_WD    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  localparam int STRB_WD   = DATA_WD / 8,
  localparam int CMD_WD    = 1 + STRB_WD + ADDR_WD + DATA_WD,
  localparam int CNT_WD    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CMD_WD-1:0]  cmd_in,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  output logic [CNT_WD-1:0]  fifo_cnt,
  output logic               rsp_vld,
  output logic               rsp_write,
  output logic [DATA_WD-1:0] rsp_data,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic [ADDR_WD-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DATA_WD-1:0] pwdata,
  output logic [STRB_WD-1:0] pstrb,
  input  logic [DATA_WD-1:0] prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int PTR_WD  = $clog2(FIFO_DEPTH);
  localparam int WAIT_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [CMD_WD-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_WD-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_WD-1:0]   cnt_q;
  logic [WAIT_WD-1:0]  wait_q, wait_d;
  logic                push, pop, fifo_empty, done, timed_out;
  logic [CMD_WD-1:0]   head;

  logic [ADDR_WD-1:0]  paddr_q;
  logic                pwrite_q;
  logic [DATA_WD-1:0]  pwdata_q;
  logic [STRB_WD-1:0]  pstrb_q;
  logic                rsp_vld_q, rsp_write_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_WD-1:0]  rsp_data_q;

  // Ready comes only from the stored count, so a full FIFO never accepts even while popping.
  assign fifo_empty = (cnt_q == '0);
  assign cmd_rdy    = (cnt_q != CNT_WD'(FIFO_DEPTH));
  assign push       = cmd_vld && cmd_rdy;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_cnt   = cnt_q;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timed_out = (state_q == ACCESS) && !pready && (wait_q == WAIT_WD'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timed_out = 1'b0;
    end
  endgenerate

  assign done = (state_q == ACCESS) && (pready || timed_out);
  assign pop  = !fifo_empty && ((state_q == IDLE) || done);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      wait_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
      cnt_q   <= cnt_q + CNT_WD'(push) - CNT_WD'(pop);
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (done) state_d = fifo_empty ? IDLE : SETUP;
        else      wait_d  = wait_q + WAIT_WD'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer fields are captured at pop and held until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (pop) begin
      paddr_q  <= head[DATA_WD +: ADDR_WD];
      pwrite_q <= head[CMD_WD-1];
      pwdata_q <= head[DATA_WD-1:0];
      pstrb_q  <= head[CMD_WD-1] ? head[ADDR_WD+DATA_WD +: STRB_WD] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q     <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_vld_q <= done;
      if (done) begin
        rsp_write_q   <= pwrite_q;
        rsp_data_q    <= (pready && !pwrite_q) ? prdata : '0;
        rsp_err_q     <= pready ? pslverr : 1'b1;
        rsp_timeout_q <= !pready;
      end
    end
  end

  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
